// File: rtl/kd_tree_root_ctrl_pkg.sv
// kd_tree_root_ctrl_pkg: node command codes, bus widths and sequencer state encodings.
package kd_tree_root_ctrl_pkg;
  localparam int CMD_SIZE = 5;
  localparam int DATA_SIZE = 24;
  localparam int AXIS_SIZE = 2;
  localparam logic [CMD_SIZE-1:0] CMD_NOP              = 5'b00000;
  localparam logic [CMD_SIZE-1:0] CMD_RST              = 5'b11111;
  localparam logic [CMD_SIZE-1:0] CMD_RST_DONE         = 5'b11110;
  localparam logic [CMD_SIZE-1:0] CMD_CENTER_FILL      = 5'b00001;
  localparam logic [CMD_SIZE-1:0] CMD_CFG_AXIS         = 5'b00010;
  localparam logic [CMD_SIZE-1:0] CMD_CENTER_FILL_DONE = 5'b00101;
  localparam logic [CMD_SIZE-1:0] CMD_CFG_AXIS_DONE    = 5'b00111;
  typedef enum logic [2:0] {S_IDLE, S_RESET, S_LOAD, S_FILL, S_HOLD, S_AXIS, S_DONE} state_t;
endpackage

// File: rtl/kd_center_fifo.sv
// kd_center_fifo: show-ahead synchronous center buffer with async reset; push when full is allowed alongside a pop.
module kd_center_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic w_pop, w_push;
  assign w_pop = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign dout = r_mem[r_rd];
  assign count = r_count;
  assign full = r_count == (AW+1)'(DEPTH);
  assign empty = r_count == '0;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/kd_tree_root_ctrl.sv
// kd_tree_root_ctrl: sequences tree reset, buffered center broadcast and sort-axis setup on the root node port.
module kd_tree_root_ctrl
  import kd_tree_root_ctrl_pkg::*;
#(
  parameter int NUM_CENTERS = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AXIS_SIZE-1:0] axis_in,
  input  logic [DATA_SIZE-1:0] center_in,
  input  logic                 center_in_valid,
  output logic                 center_in_ready,
  output logic [CMD_SIZE-1:0]  command_to_root,
  output logic [DATA_SIZE-1:0] data_to_root,
  input  logic [CMD_SIZE-1:0]  command_from_root,
  input  logic [DATA_SIZE-1:0] data_from_root,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = $clog2(NUM_CENTERS) + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t r_state;
  logic [CMD_SIZE-1:0] r_cmd;
  logic [DATA_SIZE-1:0] r_data;
  logic [AXIS_SIZE-1:0] r_axis;
  logic [WW-1:0] r_wait;
  logic [FW-1:0] r_fill;
  logic r_done, r_error;
  logic [DATA_SIZE-1:0] w_dout;
  logic [CW-1:0] w_count;
  logic w_full, w_empty, w_pop, w_reply, w_tmo, w_unused_root;
  logic [CMD_SIZE-1:0] w_expect;
  assign w_unused_root = ^data_from_root;
  assign w_pop = r_state == S_FILL && !w_empty;
  // a pop frees a slot this same cycle, so a full buffer can still take a center
  assign center_in_ready = ~w_full | w_pop;
  assign w_expect = r_state == S_RESET ? CMD_RST_DONE : r_state == S_HOLD ? CMD_CENTER_FILL_DONE : CMD_CFG_AXIS_DONE;
  assign w_reply = command_from_root == w_expect;
  assign w_tmo = r_wait == WW'(TIMEOUT - 1);
  assign command_to_root = r_cmd;
  assign data_to_root = r_data;
  assign busy = r_state != S_IDLE;
  assign done = r_done;
  assign error = r_error;
  kd_center_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_SIZE)) u_fifo (
    .clk(clk), .rst(rst), .push(center_in_valid & center_in_ready), .pop(w_pop),
    .din(center_in), .dout(w_dout), .count(w_count), .full(w_full), .empty(w_empty)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_cmd <= CMD_NOP;
      r_data <= '0;
      r_axis <= '0;
      r_wait <= '0;
      r_fill <= '0;
      r_done <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_RESET;
          r_cmd <= CMD_RST;
          r_data <= '0;
          r_axis <= axis_in;
          r_error <= 1'b0;
          r_wait <= '0;
        end
        S_RESET, S_HOLD, S_AXIS:
          if (w_reply) begin
            r_wait <= '0;
            r_state <= r_state == S_RESET ? S_LOAD : r_state == S_HOLD ? S_AXIS : S_DONE;
            r_cmd <= r_state == S_HOLD ? CMD_CFG_AXIS : CMD_NOP;
            r_data <= r_state == S_HOLD ? {{(DATA_SIZE-AXIS_SIZE){1'b0}}, r_axis} : '0;
            r_done <= r_state == S_AXIS;
          end else if (w_tmo) begin
            r_state <= S_IDLE;
            r_cmd <= CMD_NOP;
            r_data <= '0;
            r_error <= 1'b1;
          end else r_wait <= r_wait + WW'(1);
        S_LOAD: begin
          r_fill <= '0;
          if (w_count >= CW'(NUM_CENTERS)) r_state <= S_FILL;
        end
        S_FILL: begin
          r_cmd <= CMD_CENTER_FILL;
          r_data <= w_dout;
          r_fill <= r_fill + FW'(1);
          if (r_fill == FW'(NUM_CENTERS - 1)) begin
            r_state <= S_HOLD;
            r_wait <= '0;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
endmodule
